// File: rtl/reorder_buffer_param_if.sv
// Dispatch / completion / retire bus of the reorder buffer.
// master = front end + execution units, slave = the ROB itself.
interface reorder_buffer_param_if #(
  parameter int DISP_W = 2,
  parameter int CMP_W  = 4,
  parameter int RET_W  = 2,
  parameter int PREG_W = 6,
  parameter int XLEN   = 32,
  parameter int IDX_W  = 6
);
  logic                              flush;
  // dispatch
  logic [DISP_W-1:0]                 disp_valid;
  logic                              disp_ready;
  logic [DISP_W-1:0][PREG_W-1:0]     disp_dest;
  logic [DISP_W-1:0][PREG_W-1:0]     disp_old_dest;
  logic [DISP_W-1:0]                 disp_has_dest;
  logic [DISP_W-1:0]                 disp_is_store;
  logic [DISP_W-1:0][XLEN-1:0]       disp_pc;
  logic [DISP_W-1:0][IDX_W-1:0]      disp_tag;
  // completion
  logic [CMP_W-1:0]                  cmp_valid;
  logic [CMP_W-1:0][IDX_W-1:0]       cmp_tag;
  logic [CMP_W-1:0][XLEN-1:0]        cmp_data;
  // retire
  logic [RET_W-1:0]                  ret_valid;
  logic [RET_W-1:0][PREG_W-1:0]      ret_dest;
  logic [RET_W-1:0][PREG_W-1:0]      ret_old_dest;
  logic [RET_W-1:0][XLEN-1:0]        ret_data;
  logic [RET_W-1:0][XLEN-1:0]        ret_pc;
  logic [RET_W-1:0]                  ret_has_dest;
  logic [RET_W-1:0]                  ret_is_store;
  // occupancy
  logic [IDX_W:0]                    count;
  logic                              empty;

  modport master (
    output flush, disp_valid, disp_dest, disp_old_dest, disp_has_dest,
           disp_is_store, disp_pc, cmp_valid, cmp_tag, cmp_data,
    input  disp_ready, disp_tag, ret_valid, ret_dest, ret_old_dest,
           ret_data, ret_pc, ret_has_dest, ret_is_store, count, empty
  );

  modport slave (
    input  flush, disp_valid, disp_dest, disp_old_dest, disp_has_dest,
           disp_is_store, disp_pc, cmp_valid, cmp_tag, cmp_data,
    output disp_ready, disp_tag, ret_valid, ret_dest, ret_old_dest,
           ret_data, ret_pc, ret_has_dest, ret_is_store, count, empty
  );
endinterface

// File: rtl/reorder_buffer_param.sv
// Parameterized reorder buffer: circular buffer with multi-lane in-order
// dispatch, out-of-order completion by tag and in-order multi-lane retire.
module reorder_buffer_param #(
  parameter int DEPTH  = 64,
  parameter int DISP_W = 2,
  parameter int CMP_W  = 4,
  parameter int RET_W  = 2,
  parameter int PREG_W = 6,
  parameter int XLEN   = 32
) (
  input  logic clk,
  input  logic rst,
  reorder_buffer_param_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W+1:0] DEPTH_X = (IDX_W+2)'(DEPTH);
  localparam logic [IDX_W+1:0] DISP_X  = (IDX_W+2)'(DISP_W);
  localparam logic [IDX_W:0]   CNT_ONE = (IDX_W+1)'(1);

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              has_dest;
    logic              is_store;
    logic [PREG_W-1:0] dest;
    logic [PREG_W-1:0] old_dest;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   data;
  } entry_t;

  entry_t           rob_q [DEPTH];
  logic [IDX_W-1:0] head_q, tail_q;
  logic [IDX_W:0]   count_q;

  logic             disp_ok;
  logic [IDX_W:0]   acc_cnt, ret_cnt;
  logic [RET_W-1:0] ret_run;
  logic [IDX_W-1:0] ret_idx [RET_W];

  logic [RET_W-1:0]             ret_valid_q, ret_has_dest_q, ret_is_store_q;
  logic [RET_W-1:0][PREG_W-1:0] ret_dest_q, ret_old_dest_q;
  logic [RET_W-1:0][XLEN-1:0]   ret_data_q, ret_pc_q;

  // Ready uses the pre-edge count only: same-edge retires are not credited,
  // so a dispatch never lands on a slot being freed in the same edge.
  assign disp_ok = !bus.flush && ((DEPTH_X - {1'b0, count_q}) >= DISP_X);

  assign bus.disp_ready = disp_ok;
  assign bus.count      = count_q;
  assign bus.empty      = (count_q == '0);

  // Allocated tags and retire slot indices wrap naturally in IDX_W bits
  for (genvar k = 0; k < DISP_W; k++) begin : g_tag
    assign bus.disp_tag[k] = tail_q + IDX_W'(k);
  end
  for (genvar r = 0; r < RET_W; r++) begin : g_ridx
    assign ret_idx[r] = head_q + IDX_W'(r);
  end

  // Number of dispatch lanes accepted this edge
  always_comb begin
    acc_cnt = '0;
    for (int k = 0; k < DISP_W; k++)
      if (disp_ok && bus.disp_valid[k]) acc_cnt = acc_cnt + CNT_ONE;
  end

  // Longest valid+done run from head, capped at RET_W
  always_comb begin
    logic run;
    run     = 1'b1;
    ret_run = '0;
    ret_cnt = '0;
    for (int r = 0; r < RET_W; r++) begin
      if (run && rob_q[ret_idx[r]].valid && rob_q[ret_idx[r]].done) begin
        ret_run[r] = 1'b1;
        ret_cnt    = ret_cnt + CNT_ONE;
      end else begin
        run = 1'b0;
      end
    end
  end

  // Entry storage and pointers; completion, then retire clear, then dispatch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rob_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i].valid <= 1'b0;
        rob_q[i].done  <= 1'b0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // later ports overwrite earlier ones on a shared tag
      for (int j = 0; j < CMP_W; j++) begin
        if (bus.cmp_valid[j] && rob_q[bus.cmp_tag[j]].valid) begin
          rob_q[bus.cmp_tag[j]].done <= 1'b1;
          rob_q[bus.cmp_tag[j]].data <= bus.cmp_data[j];
        end
      end
      for (int r = 0; r < RET_W; r++) begin
        if (ret_run[r]) begin
          rob_q[ret_idx[r]].valid <= 1'b0;
          rob_q[ret_idx[r]].done  <= 1'b0;
        end
      end
      for (int k = 0; k < DISP_W; k++) begin
        if (disp_ok && bus.disp_valid[k]) begin
          rob_q[tail_q + IDX_W'(k)] <= '{valid:    1'b1,
                                        done:     1'b0,
                                        has_dest: bus.disp_has_dest[k],
                                        is_store: bus.disp_is_store[k],
                                        dest:     bus.disp_dest[k],
                                        old_dest: bus.disp_old_dest[k],
                                        pc:       bus.disp_pc[k],
                                        data:     '0};
        end
      end
      head_q  <= head_q + ret_cnt[IDX_W-1:0];
      tail_q  <= tail_q + acc_cnt[IDX_W-1:0];
      count_q <= count_q + acc_cnt - ret_cnt;
    end
  end

  // Registered retire lanes; idle lanes keep their last payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_valid_q    <= '0;
      ret_has_dest_q <= '0;
      ret_is_store_q <= '0;
      ret_dest_q     <= '0;
      ret_old_dest_q <= '0;
      ret_data_q     <= '0;
      ret_pc_q       <= '0;
    end else if (bus.flush) begin
      ret_valid_q <= '0;
    end else begin
      ret_valid_q <= ret_run;
      for (int r = 0; r < RET_W; r++) begin
        if (ret_run[r]) begin
          ret_has_dest_q[r] <= rob_q[ret_idx[r]].has_dest;
          ret_is_store_q[r] <= rob_q[ret_idx[r]].is_store;
          ret_dest_q[r]     <= rob_q[ret_idx[r]].dest;
          ret_old_dest_q[r] <= rob_q[ret_idx[r]].old_dest;
          ret_data_q[r]     <= rob_q[ret_idx[r]].data;
          ret_pc_q[r]       <= rob_q[ret_idx[r]].pc;
        end
      end
    end
  end

  assign bus.ret_valid    = ret_valid_q;
  assign bus.ret_has_dest = ret_has_dest_q;
  assign bus.ret_is_store = ret_is_store_q;
  assign bus.ret_dest     = ret_dest_q;
  assign bus.ret_old_dest = ret_old_dest_q;
  assign bus.ret_data     = ret_data_q;
  assign bus.ret_pc       = ret_pc_q;
endmodule

// File: tb/tb_reorder_buffer_param.sv
// Bench for reorder_buffer_param: table of single-cycle vectors, hand-written
// corner sequences, and an in-order retire scoreboard with occupancy model.
module tb_reorder_buffer_param;
  localparam logic [31:0] DKEY = 32'hDEAD_0000;

  logic clk, rst;
  reorder_buffer_param_if #(.DISP_W(2), .CMP_W(4), .RET_W(2), .PREG_W(6),
                            .XLEN(32), .IDX_W(6)) bus ();

  reorder_buffer_param #(.DEPTH(64), .DISP_W(2), .CMP_W(4), .RET_W(2),
                         .PREG_W(6), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [5:0]  dest;
    logic [5:0]  old_dest;
    logic        has_dest;
    logic        is_store;
  } sb_t;

  typedef struct {
    logic [1:0]  dv;
    logic [31:0] pc0, pc1;
    logic        cv;
    logic [5:0]  ct;
    logic [5:0]  tag0, tag1;
    int          cnt;
    logic        rdy;
    logic [1:0]  rv;
    logic [31:0] rpc0, rpc1;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  sb_t         sbq [$];
  logic        mvalid [64];
  logic        mdone  [64];
  logic [31:0] mpc    [64];
  logic [5:0]  mhead, mtail;
  int          mcount;
  logic [1:0]  exp_rv;
  logic        mon_en;
  sb_t         mon_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mvalid[i] = 1'b0;
      mdone[i]  = 1'b0;
    end
    mhead = '0; mtail = '0; mcount = 0; exp_rv = '0;
    sbq.delete();
  endtask

  // Called at the active edge with the stimulus still applied
  task automatic model_update();
    int ret, acc;
    logic rdy;
    logic [5:0] idx;
    sb_t rec;
    rdy = (mcount <= 62) && !bus.flush;
    if (bus.flush) begin
      model_reset();
      return;
    end
    ret = 0;
    for (int r = 0; r < 2; r++) begin
      idx = mhead + 6'(r);
      if (ret == r && mvalid[idx] && mdone[idx]) ret++;
    end
    for (int j = 0; j < 4; j++)
      if (bus.cmp_valid[j] && mvalid[bus.cmp_tag[j]]) mdone[bus.cmp_tag[j]] = 1'b1;
    for (int r = 0; r < ret; r++) begin
      idx = mhead + 6'(r);
      mvalid[idx] = 1'b0;
      mdone[idx]  = 1'b0;
    end
    acc = 0;
    for (int k = 0; k < 2; k++) begin
      if (bus.disp_valid[k] && rdy) begin
        idx = mtail + 6'(k);
        mvalid[idx] = 1'b1;
        mdone[idx]  = 1'b0;
        mpc[idx]    = bus.disp_pc[k];
        rec.pc       = bus.disp_pc[k];
        rec.data     = bus.disp_pc[k] ^ DKEY;
        rec.dest     = bus.disp_dest[k];
        rec.old_dest = bus.disp_old_dest[k];
        rec.has_dest = bus.disp_has_dest[k];
        rec.is_store = bus.disp_is_store[k];
        sbq.push_back(rec);
        acc++;
      end
    end
    mtail  = mtail + 6'(acc);
    mhead  = mhead + 6'(ret);
    mcount = mcount + acc - ret;
    exp_rv = (ret == 2) ? 2'b11 : (ret == 1) ? 2'b01 : 2'b00;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_disp(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
    logic [31:0] p [2];
    p[0] = p0; p[1] = p1;
    bus.disp_valid = v;
    for (int k = 0; k < 2; k++) begin
      bus.disp_pc[k]       = p[k];
      bus.disp_dest[k]     = p[k][7:2];
      bus.disp_old_dest[k] = p[k][13:8];
      bus.disp_has_dest[k] = ~p[k][3];
      bus.disp_is_store[k] = p[k][3];
    end
  endtask

  task automatic clr_cmp();
    bus.cmp_valid = '0;
    bus.cmp_tag   = '0;
    bus.cmp_data  = '0;
  endtask

  task automatic cmp(input int port, input logic [5:0] tag);
    bus.cmp_valid[port] = 1'b1;
    bus.cmp_tag[port]   = tag;
    bus.cmp_data[port]  = mpc[tag] ^ DKEY;
  endtask

  task automatic cmp_junk(input int port, input logic [5:0] tag);
    bus.cmp_valid[port] = 1'b1;
    bus.cmp_tag[port]   = tag;
    bus.cmp_data[port]  = 32'hBAD0_BAD0;
  endtask

  task automatic idle();
    set_disp(2'b00, 32'h0, 32'h0);
    clr_cmp();
    bus.flush = 1'b0;
  endtask

  // Scoreboard / occupancy monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ret_valid", 64'(bus.ret_valid), 64'(exp_rv));
      chk("count", 64'(bus.count), 64'(mcount));
      chk("empty", 64'(bus.empty), 64'(mcount == 0));
      chk("disp_ready", 64'(bus.disp_ready), 64'((mcount <= 62) && !bus.flush));
      for (int r = 0; r < 2; r++) begin
        if (exp_rv[r]) begin
          if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_underflow lane %0d: got retire expected none", r);
          end else begin
            mon_e = sbq.pop_front();
            chk("ret_pc", 64'(bus.ret_pc[r]), 64'(mon_e.pc));
            chk("ret_data", 64'(bus.ret_data[r]), 64'(mon_e.data));
            chk("ret_has_dest", 64'(bus.ret_has_dest[r]), 64'(mon_e.has_dest));
            chk("ret_is_store", 64'(bus.ret_is_store[r]), 64'(mon_e.is_store));
            if (mon_e.has_dest) begin
              chk("ret_dest", 64'(bus.ret_dest[r]), 64'(mon_e.dest));
              chk("ret_old_dest", 64'(bus.ret_old_dest[r]), 64'(mon_e.old_dest));
            end
          end
        end
      end
    end
  end

  vec_t tv [5];

  initial begin
    tv[0] = '{dv:2'b11, pc0:32'h100, pc1:32'h104, cv:1'b0, ct:6'd0, tag0:6'd0, tag1:6'd1,
              cnt:2, rdy:1'b1, rv:2'b00, rpc0:32'h0, rpc1:32'h0};
    tv[1] = '{dv:2'b00, pc0:32'h0, pc1:32'h0, cv:1'b1, ct:6'd1, tag0:6'd2, tag1:6'd3,
              cnt:2, rdy:1'b1, rv:2'b00, rpc0:32'h0, rpc1:32'h0};
    tv[2] = '{dv:2'b00, pc0:32'h0, pc1:32'h0, cv:1'b1, ct:6'd0, tag0:6'd2, tag1:6'd3,
              cnt:2, rdy:1'b1, rv:2'b00, rpc0:32'h0, rpc1:32'h0};
    tv[3] = '{dv:2'b00, pc0:32'h0, pc1:32'h0, cv:1'b0, ct:6'd0, tag0:6'd2, tag1:6'd3,
              cnt:0, rdy:1'b1, rv:2'b11, rpc0:32'h100, rpc1:32'h104};
    tv[4] = '{dv:2'b00, pc0:32'h0, pc1:32'h0, cv:1'b0, ct:6'd0, tag0:6'd2, tag1:6'd3,
              cnt:0, rdy:1'b1, rv:2'b00, rpc0:32'h0, rpc1:32'h0};

    mon_en = 1'b0;
    model_reset();
    idle();
    rst = 1'b1;
    #3;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_ret_valid", 64'(bus.ret_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    chk("post_rst_ready", 64'(bus.disp_ready), 64'd1);

    // basic dispatch / out-of-order completion / paired retire
    for (int s = 0; s < 5; s++) begin
      set_disp(tv[s].dv, tv[s].pc0, tv[s].pc1);
      clr_cmp();
      if (tv[s].cv) cmp(0, tv[s].ct);
      chk("tbl_tag0", 64'(bus.disp_tag[0]), 64'(tv[s].tag0));
      chk("tbl_tag1", 64'(bus.disp_tag[1]), 64'(tv[s].tag1));
      tick();
      chk("tbl_count", 64'(bus.count), 64'(tv[s].cnt));
      chk("tbl_ready", 64'(bus.disp_ready), 64'(tv[s].rdy));
      chk("tbl_ret_valid", 64'(bus.ret_valid), 64'(tv[s].rv));
      if (tv[s].rv[0]) chk("tbl_ret_pc0", 64'(bus.ret_pc[0]), 64'(tv[s].rpc0));
      if (tv[s].rv[1]) chk("tbl_ret_pc1", 64'(bus.ret_pc[1]), 64'(tv[s].rpc1));
    end

    // fill to DEPTH; ready needs two free slots
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int i = 0; i < 32; i++) begin
      set_disp(2'b11, 32'h1000 + 32'(8 * i), 32'h1004 + 32'(8 * i));
      tick();
    end
    set_disp(2'b11, 32'h5000, 32'h5004);
    chk("full_count", 64'(bus.count), 64'd64);
    chk("full_ready", 64'(bus.disp_ready), 64'd0);
    cmp(0, 6'd0);
    tick();
    idle();
    tick();
    chk("full_ret1_valid", 64'(bus.ret_valid), 64'b01);
    chk("full_ret1_pc", 64'(bus.ret_pc[0]), 64'h1000);
    chk("full_ret1_count", 64'(bus.count), 64'd63);
    chk("full_ret1_ready", 64'(bus.disp_ready), 64'd0);
    cmp(0, 6'd1);
    tick();
    clr_cmp();
    tick();
    chk("full_ret2_count", 64'(bus.count), 64'd62);
    chk("full_ret2_ready", 64'(bus.disp_ready), 64'd1);

    // walk pointers to 62, then dispatch across the wrap point
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int i = 0; i < 31; i++) begin
      set_disp(2'b11, 32'h2000 + 32'(8 * i), 32'h2004 + 32'(8 * i));
      clr_cmp();
      if (i > 0) begin
        cmp(0, 6'(2 * i - 2));
        cmp(1, 6'(2 * i - 1));
      end
      tick();
    end
    idle();
    cmp_junk(0, 6'd60);
    cmp(1, 6'd61);
    cmp_junk(2, 6'd5);
    cmp(3, 6'd60);
    tick();
    clr_cmp();
    repeat (3) tick();
    chk("wrap_drained", 64'(bus.count), 64'd0);
    chk("wrap_tag0", 64'(bus.disp_tag[0]), 64'd62);
    chk("wrap_tag1", 64'(bus.disp_tag[1]), 64'd63);
    set_disp(2'b11, 32'h3000, 32'h3004);
    tick();
    chk("wrap_tag2", 64'(bus.disp_tag[0]), 64'd0);
    chk("wrap_tag3", 64'(bus.disp_tag[1]), 64'd1);
    set_disp(2'b11, 32'h3008, 32'h300C);
    tick();
    set_disp(2'b00, 32'h0, 32'h0);
    cmp(0, 6'd62); cmp(1, 6'd63); cmp(2, 6'd0); cmp(3, 6'd1);
    tick();
    clr_cmp();
    tick();
    chk("wrap_ret_a0", 64'(bus.ret_pc[0]), 64'h3000);
    chk("wrap_ret_a1", 64'(bus.ret_pc[1]), 64'h3004);
    tick();
    chk("wrap_ret_b0", 64'(bus.ret_pc[0]), 64'h3008);
    chk("wrap_ret_b1", 64'(bus.ret_pc[1]), 64'h300C);
    chk("wrap_count", 64'(bus.count), 64'd0);

    // simultaneous dispatch/complete/retire, then flush on top of it
    set_disp(2'b11, 32'h4000, 32'h4004);
    tick();
    set_disp(2'b11, 32'h4008, 32'h400C);
    tick();
    set_disp(2'b11, 32'h4010, 32'h4014);
    cmp(0, 6'd2); cmp(1, 6'd3);
    tick();
    set_disp(2'b11, 32'h4018, 32'h401C);
    clr_cmp();
    cmp(0, 6'd4); cmp(1, 6'd5); cmp(2, 6'd6); cmp(3, 6'd7);
    tick();
    chk("busy_count", 64'(bus.count), 64'd6);
    chk("busy_ret_valid", 64'(bus.ret_valid), 64'b11);
    chk("busy_ret_pc0", 64'(bus.ret_pc[0]), 64'h4000);
    set_disp(2'b11, 32'h4020, 32'h4024);
    clr_cmp();
    bus.flush = 1'b1;
    tick();
    chk("flush_count", 64'(bus.count), 64'd0);
    chk("flush_ret_valid", 64'(bus.ret_valid), 64'd0);
    chk("flush_empty", 64'(bus.empty), 64'd1);
    idle();
    tick();

    // asynchronous reset in the middle of a cycle
    for (int i = 0; i < 5; i++) begin
      set_disp(2'b11, 32'h6000 + 32'(8 * i), 32'h6004 + 32'(8 * i));
      tick();
    end
    idle();
    chk("pre_rst_count", 64'(bus.count), 64'd10);
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 64'(bus.count), 64'd0);
    chk("arst_empty", 64'(bus.empty), 64'd1);
    chk("arst_ret_valid", 64'(bus.ret_valid), 64'd0);
    chk("arst_ret_pc", 64'(bus.ret_pc), 64'd0);
    chk("arst_ret_data", 64'(bus.ret_data), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;
    chk("arst_ready", 64'(bus.disp_ready), 64'd1);
    chk("arst_tag0", 64'(bus.disp_tag[0]), 64'd0);

    // life after reset
    set_disp(2'b11, 32'h7000, 32'h7004);
    tick();
    set_disp(2'b00, 32'h0, 32'h0);
    cmp(0, 6'd0); cmp(1, 6'd1);
    tick();
    clr_cmp();
    tick();
    chk("final_ret_valid", 64'(bus.ret_valid), 64'b11);
    chk("final_ret_pc1", 64'(bus.ret_pc[1]), 64'h7004);
    tick();
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
